// File: rtl/pic_pkg.sv
// Shared types and priority helpers for the 8259 interrupt sequencer.
package pic_pkg;

    localparam int NUM_IR = 8;
    localparam logic [2:0] SPURIOUS_LVL = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK1,
        ACK2
    } pic_state_t;

    // Returns {valid, level} of the highest-priority set bit; level lowest+1 wins first.
    function automatic logic [3:0] rot_first(input logic [7:0] vec, input logic [2:0] lowest);
        logic [3:0] r;
        logic [2:0] l;
        r = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            l = lowest + 3'(k) + 3'd1;
            if (vec[l]) r = {1'b1, l};
        end
        return r;
    endfunction

    // Rank 0 is the highest priority under the current rotation.
    function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lowest);
        return lvl - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/pic_int_sequencer_if.sv
// CPU-side acknowledge/data-bus signals of the interrupt sequencer.
interface pic_int_sequencer_if;
    logic       inta;
    logic       int_out;
    logic [7:0] dout;
    logic       dout_en;

    modport master (output inta, input int_out, input dout, input dout_en);
    modport slave  (input inta, output int_out, output dout, output dout_en);
endinterface

// File: rtl/pic_priority_resolver.sv
// Rotating priority encoder: finds the highest-priority set bit given the lowest-priority level.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] vec,
    input  logic [2:0]        lowest,
    output logic              valid,
    output logic [2:0]        lvl
);

    assign {valid, lvl} = rot_first(vec, lowest);

endmodule

// File: rtl/pic_int_sequencer.sv
// 8259 interrupt sequencing: IRR/ISR bookkeeping, priority resolution and the two-pulse INTA handshake.
module pic_int_sequencer
    import pic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic [NUM_IR-1:0] ir,
    input  logic [NUM_IR-1:0] imr,
    input  logic              ltim,
    input  logic              aeoi,
    input  logic [4:0]        vec_base,
    input  logic              eoi_ns,
    input  logic              eoi_sp,
    input  logic              rot_ns,
    input  logic              set_pri,
    input  logic [2:0]        cmd_lvl,
    pic_int_sequencer_if.slave bus,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] isr
);

    pic_state_t        state, state_nxt;
    logic [NUM_IR-1:0] ir_p1;
    logic              inta_p1;
    logic [2:0]        lowest, lowest_nxt, cur_lvl;
    logic              spur;
    logic              req_v, isr_v;
    logic [2:0]        req_lvl, isr_lvl;
    logic              req_ok, inta_fall, inta_rise, take, ack_valid;
    logic [NUM_IR-1:0] irr_nxt, isr_nxt;
    logic              int_out_r, dout_en_r;
    logic [7:0]        dout_r;

    pic_priority_resolver u_req (.vec(irr & ~imr), .lowest(lowest), .valid(req_v), .lvl(req_lvl));
    pic_priority_resolver u_isr (.vec(isr),        .lowest(lowest), .valid(isr_v), .lvl(isr_lvl));

    assign inta_fall = inta_p1 & ~bus.inta;
    assign inta_rise = ~inta_p1 & bus.inta;
    assign req_ok    = req_v && (!isr_v || (prio_rank(req_lvl, lowest) < prio_rank(isr_lvl, lowest)));

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        unique case (state)
            IDLE: if (inta_fall) begin
                      state_nxt = ACK1;
                      take      = 1'b1;
                  end else if (req_ok) begin
                      state_nxt = REQ;
                  end
            REQ:  if (inta_fall) begin
                      state_nxt = ACK1;
                      take      = 1'b1;
                  end else if (!req_ok) begin
                      state_nxt = IDLE;
                  end
            ACK1: if (inta_fall) state_nxt = ACK2;
            ACK2: if (inta_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!init_done) begin
            state_nxt = IDLE;
            take      = 1'b0;
        end
        // An acknowledge from IDLE is always spurious, even if a request just appeared.
        ack_valid = take && (state == REQ) && req_ok;
    end

    always_comb begin
        irr_nxt = ltim ? ir : (irr | (ir & ~ir_p1));
        if (ltim && (state == ACK1 || state == ACK2) && !spur) irr_nxt[cur_lvl] = irr[cur_lvl];
        if (ack_valid) irr_nxt[req_lvl] = 1'b0;

        isr_nxt    = isr;
        lowest_nxt = lowest;
        if ((rot_ns || eoi_ns) && isr_v) isr_nxt[isr_lvl] = 1'b0;
        if (rot_ns && isr_v) lowest_nxt = isr_lvl;
        if (eoi_sp) isr_nxt[cmd_lvl] = 1'b0;
        if (set_pri) lowest_nxt = cmd_lvl;
        if (state == ACK2 && inta_rise && aeoi && !spur) isr_nxt[cur_lvl] = 1'b0;
        if (ack_valid) isr_nxt[req_lvl] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ir_p1     <= '0;
            inta_p1   <= 1'b1;
            irr       <= '0;
            isr       <= '0;
            lowest    <= 3'd7;
            cur_lvl   <= SPURIOUS_LVL;
            spur      <= 1'b0;
            int_out_r <= 1'b0;
            dout_r    <= 8'h00;
            dout_en_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            ir_p1     <= ir;
            inta_p1   <= bus.inta;
            int_out_r <= (state_nxt == REQ);
            dout_en_r <= (state_nxt == ACK2);
            if (state == ACK1 && state_nxt == ACK2) dout_r <= {vec_base, cur_lvl};
            if (take) begin
                cur_lvl <= ack_valid ? req_lvl : SPURIOUS_LVL;
                spur    <= !ack_valid;
            end
            if (!init_done) begin
                irr    <= '0;
                isr    <= '0;
                lowest <= 3'd7;
            end else begin
                irr    <= irr_nxt;
                isr    <= isr_nxt;
                lowest <= lowest_nxt;
            end
        end
    end

    assign bus.int_out = int_out_r;
    assign bus.dout    = dout_r;
    assign bus.dout_en = dout_en_r;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Directed-vector bench for pic_int_sequencer with hand-computed expectations.
module tb_pic_int_sequencer;
    logic       clk = 1'b0;
    logic       rst, init_done, ltim, aeoi;
    logic [7:0] ir, imr, irr, isr;
    logic [4:0] vec_base;
    logic       eoi_ns, eoi_sp, rot_ns, set_pri;
    logic [2:0] cmd_lvl;
    int         errors = 0;
    int         checks = 0;

    pic_int_sequencer_if bus();

    pic_int_sequencer dut (
        .clk(clk), .rst(rst), .init_done(init_done), .ir(ir), .imr(imr),
        .ltim(ltim), .aeoi(aeoi), .vec_base(vec_base),
        .eoi_ns(eoi_ns), .eoi_sp(eoi_sp), .rot_ns(rot_ns), .set_pri(set_pri),
        .cmd_lvl(cmd_lvl), .bus(bus), .irr(irr), .isr(isr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pin(input logic v);
        bus.inta = v;
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; init_done = 1'b0; ltim = 1'b0; aeoi = 1'b0;
        ir = 8'h00; imr = 8'h00; vec_base = 5'h08;
        eoi_ns = 0; eoi_sp = 0; rot_ns = 0; set_pri = 0; cmd_lvl = 3'd0;
        bus.inta = 1'b1;
        step(2);
        chk("rst_int_out", {7'b0, bus.int_out}, 8'h00);
        chk("rst_dout_en", {7'b0, bus.dout_en}, 8'h00);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_irr", irr, 8'h00);
        chk("rst_isr", isr, 8'h00);
        rst = 1'b0; init_done = 1'b1;
        step(1);

        // Edge request on IR2
        ir = 8'h04;
        step(1);
        chk("edge_irr", irr, 8'h04);
        chk("edge_int_early", {7'b0, bus.int_out}, 8'h00);
        step(1);
        chk("edge_int_out", {7'b0, bus.int_out}, 8'h01);
        pin(0);
        chk("edge_isr", isr, 8'h04);
        chk("edge_irr_clr", irr, 8'h00);
        chk("edge_int_drop", {7'b0, bus.int_out}, 8'h00);
        pin(1); pin(0);
        chk("edge_dout", bus.dout, 8'h42);
        chk("edge_dout_en", {7'b0, bus.dout_en}, 8'h01);
        pin(1);
        chk("edge_dout_en_off", {7'b0, bus.dout_en}, 8'h00);
        eoi_ns = 1; step(1); eoi_ns = 0;
        chk("edge_eoi", isr, 8'h00);
        ir = 8'h00; step(1);

        // Preemption: IR5 in service, IR2 preempts, IR6 waits
        ir = 8'h20; step(2);
        pin(0); pin(1); pin(0); pin(1);
        chk("pre_isr5", isr, 8'h20);
        ir = 8'h24; step(2);
        chk("pre_ir2_int", {7'b0, bus.int_out}, 8'h01);
        pin(0); pin(1); pin(0);
        chk("pre_ir2_dout", bus.dout, 8'h42);
        pin(1);
        chk("pre_isr_both", isr, 8'h24);
        eoi_ns = 1; step(1); eoi_ns = 0;
        chk("pre_eoi_ns", isr, 8'h20);
        ir = 8'h64; step(1);
        chk("pre_irr6", irr, 8'h40);
        step(2);
        chk("pre_ir6_blocked", {7'b0, bus.int_out}, 8'h00);
        eoi_ns = 1; step(1); eoi_ns = 0;
        chk("pre_isr_empty", isr, 8'h00);
        step(1);
        chk("pre_ir6_int", {7'b0, bus.int_out}, 8'h01);
        pin(0); pin(1); pin(0);
        chk("pre_ir6_dout", bus.dout, 8'h46);
        pin(1);
        cmd_lvl = 3'd6; eoi_sp = 1; step(1); eoi_sp = 0;
        chk("pre_eoi_sp", isr, 8'h00);
        ir = 8'h00; step(1);

        // Spurious: level request removed before INTA1
        ltim = 1'b1;
        ir = 8'h08; step(2);
        chk("spur_int_out", {7'b0, bus.int_out}, 8'h01);
        ir = 8'h00; step(1);
        chk("spur_irr", irr, 8'h00);
        pin(0);
        chk("spur_isr", isr, 8'h00);
        pin(1); pin(0);
        chk("spur_dout", bus.dout, 8'h47);
        pin(1);
        chk("spur_isr_after", isr, 8'h00);
        ltim = 1'b0; step(1);

        // AEOI on IR3, IR1 arrives mid-handshake
        aeoi = 1'b1;
        ir = 8'h08; step(2);
        pin(0);
        chk("aeoi_isr_set", isr, 8'h08);
        ir = 8'h0A;
        pin(1); pin(0);
        chk("aeoi_dout", bus.dout, 8'h43);
        pin(1);
        chk("aeoi_isr_clr", isr, 8'h00);
        step(1);
        chk("aeoi_reassert", {7'b0, bus.int_out}, 8'h01);
        pin(0); pin(1); pin(0);
        chk("aeoi_ir1_dout", bus.dout, 8'h41);
        pin(1);
        ir = 8'h00; aeoi = 1'b0; step(1);

        // Rotation on non-specific EOI
        ir = 8'h08; step(2);
        pin(0); pin(1); pin(0); pin(1);
        chk("rot_isr_pre", isr, 8'h08);
        ir = 8'h00;
        rot_ns = 1; step(1); rot_ns = 0;
        chk("rot_isr_clr", isr, 8'h00);
        ir = 8'h18; step(2);
        chk("rot_int_out", {7'b0, bus.int_out}, 8'h01);
        pin(0);
        chk("rot_isr_ir4", isr, 8'h10);
        pin(1); pin(0);
        chk("rot_dout_ir4", bus.dout, 8'h44);
        pin(1);
        eoi_ns = 1; step(1); eoi_ns = 0;
        step(1);
        chk("rot_ir3_int", {7'b0, bus.int_out}, 8'h01);
        pin(0); pin(1); pin(0);
        chk("rot_ir3_dout", bus.dout, 8'h43);
        chk("rot_ir3_dout_en", {7'b0, bus.dout_en}, 8'h01);

        // init_done drop mid-ACK2
        init_done = 1'b0; step(1);
        chk("init_dout_en", {7'b0, bus.dout_en}, 8'h00);
        chk("init_isr", isr, 8'h00);
        chk("init_irr", irr, 8'h00);
        chk("init_int_out", {7'b0, bus.int_out}, 8'h00);
        bus.inta = 1'b1; ir = 8'h00; init_done = 1'b1; step(2);

        // Reset mid-ACK2
        ir = 8'h01; step(2);
        chk("rst2_int_out", {7'b0, bus.int_out}, 8'h01);
        pin(0); pin(1); pin(0);
        chk("rst2_dout", bus.dout, 8'h40);
        rst = 1'b1; bus.inta = 1'b1; ir = 8'h00; step(1);
        chk("rst2_dout_en", {7'b0, bus.dout_en}, 8'h00);
        chk("rst2_isr", isr, 8'h00);
        chk("rst2_dout_clr", bus.dout, 8'h00);
        rst = 1'b0; step(1);

        // set_pri: lowest=5 makes IR6 highest
        cmd_lvl = 3'd5; set_pri = 1; step(1); set_pri = 0;
        ir = 8'h44; step(2);
        pin(0); pin(1); pin(0);
        chk("setpri_dout", bus.dout, 8'h46);
        pin(1);
        chk("setpri_isr", isr, 8'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
